// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// states, opcodes, funct codes, ALU control codes and PC source selects.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_R_FORM = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_RS     = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU control decode: selects the ALU operation from state, opcode and funct,
// and flags whether the funct is one of the supported R-form arithmetic ops.
module multicycle_ctrl_alu_dec
   import multicycle_ctrl_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_mem_ready,
   output logic [3:0] o_alu_ctl,
   output logic       o_funct_valid
);

   logic [3:0] w_funct_ctl;

   always_comb begin
      w_funct_ctl   = ALU_AND;
      o_funct_valid = 1'b1;
      case (i_funct)
         FN_ADD:  w_funct_ctl = ALU_ADD;
         FN_SUB:  w_funct_ctl = ALU_SUB;
         FN_AND:  w_funct_ctl = ALU_AND;
         FN_OR:   w_funct_ctl = ALU_OR;
         FN_SLT:  w_funct_ctl = ALU_SLT;
         default: o_funct_valid = 1'b0;
      endcase
   end

   always_comb begin
      o_alu_ctl = ALU_AND;
      case (i_state)
         // PC+4 is only computed in the fetch cycle that actually completes
         ST_FETCH:  if (i_mem_ready) o_alu_ctl = ALU_ADD;
         ST_DECODE: o_alu_ctl = ALU_ADD;
         ST_EXEC: begin
            case (i_opcode)
               OP_R_FORM:                 o_alu_ctl = o_funct_valid ? w_funct_ctl : ALU_AND;
               OP_ADDI, OP_ADDIU:         o_alu_ctl = ALU_ADD;
               OP_LW, OP_SW:              o_alu_ctl = ALU_ADD;
               OP_SLTI:                   o_alu_ctl = ALU_SLT;
               OP_SLTIU:                  o_alu_ctl = ALU_SLTU;
               OP_BEQ:                    o_alu_ctl = ALU_SUB;
               default:                   o_alu_ctl = ALU_AND;
            endcase
         end
         default:   o_alu_ctl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory-ready
// watchdog that traps after WAIT_MAX+1 consecutive wait cycles.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pc_we,
   output logic [1:0] o_pc_src,
   output logic       o_ir_we,
   output logic       o_iord,
   output logic       o_mem_re,
   output logic       o_mem_we,
   output logic       o_reg_we,
   output logic [1:0] o_reg_dst,
   output logic [1:0] o_mem_to_reg,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [3:0] o_alu_ctl,
   output logic [2:0] o_state,
   output logic       o_illegal
);

   localparam logic [7:0] LP_WAIT_MAX = 8'(WAIT_MAX);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_nxt;
   logic       w_wait_hit;
   logic       w_funct_valid;
   logic [3:0] w_alu_ctl;

   logic       w_pc_we, w_ir_we, w_iord, w_mem_re, w_mem_we, w_reg_we;
   logic       w_alu_src_a, w_illegal;
   logic [1:0] w_pc_src, w_reg_dst, w_mem_to_reg, w_alu_src_b;

   multicycle_ctrl_alu_dec u_alu_dec (
      .i_state       (r_state),
      .i_opcode      (i_opcode),
      .i_funct       (i_funct),
      .i_mem_ready   (i_mem_ready),
      .o_alu_ctl     (w_alu_ctl),
      .o_funct_valid (w_funct_valid)
   );

   assign w_wait_hit = (r_wait_cnt == LP_WAIT_MAX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_FETCH;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   always_comb begin
      w_wait_cnt_nxt = r_wait_cnt;
      if (w_next != r_state)
         w_wait_cnt_nxt = 8'd0;
      else if ((r_state == ST_FETCH || r_state == ST_MEM) && !i_mem_ready)
         w_wait_cnt_nxt = r_wait_cnt + 8'd1;
   end

   always_comb begin
      w_next       = r_state;
      w_pc_we      = 1'b0;
      w_pc_src     = PC_ALU;
      w_ir_we      = 1'b0;
      w_iord       = 1'b0;
      w_mem_re     = 1'b0;
      w_mem_we     = 1'b0;
      w_reg_we     = 1'b0;
      w_reg_dst    = 2'b00;
      w_mem_to_reg = 2'b00;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_illegal    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_mem_re = 1'b1;
            if (i_mem_ready) begin
               w_ir_we     = 1'b1;
               w_pc_we     = 1'b1;
               w_pc_src    = PC_ALU;
               w_alu_src_b = 2'b01;
               w_next      = ST_DECODE;
            end else if (w_wait_hit) begin
               w_next = ST_TRAP;
            end
         end
         ST_DECODE: begin
            w_alu_src_b = 2'b11;
            case (i_opcode)
               OP_J: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = PC_JUMP;
                  w_next   = ST_FETCH;
               end
               OP_JAL: begin
                  w_pc_we      = 1'b1;
                  w_pc_src     = PC_JUMP;
                  w_reg_we     = 1'b1;
                  w_reg_dst    = 2'b10;
                  w_mem_to_reg = 2'b10;
                  w_next       = ST_FETCH;
               end
               OP_R_FORM, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
               OP_LW, OP_SW, OP_BEQ: w_next = ST_EXEC;
               default:              w_next = ST_TRAP;
            endcase
         end
         ST_EXEC: begin
            w_alu_src_a = 1'b1;
            case (i_opcode)
               OP_R_FORM: begin
                  if (i_funct == FN_JR) begin
                     w_pc_we  = 1'b1;
                     w_pc_src = PC_RS;
                     w_next   = ST_FETCH;
                  end else begin
                     w_next = w_funct_valid ? ST_WB : ST_TRAP;
                  end
               end
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                  w_alu_src_b = 2'b10;
                  w_next      = ST_WB;
               end
               OP_LW, OP_SW: begin
                  w_alu_src_b = 2'b10;
                  w_next      = ST_MEM;
               end
               OP_BEQ: begin
                  w_pc_src = PC_ALUOUT;
                  w_pc_we  = i_zero;
                  w_next   = ST_FETCH;
               end
               default: w_next = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            w_iord   = 1'b1;
            w_mem_re = (i_opcode == OP_LW);
            w_mem_we = (i_opcode == OP_SW);
            if (i_mem_ready)
               w_next = (i_opcode == OP_LW) ? ST_WB : ST_FETCH;
            else if (w_wait_hit)
               w_next = ST_TRAP;
         end
         ST_WB: begin
            w_reg_we     = 1'b1;
            w_reg_dst    = (i_opcode == OP_R_FORM) ? 2'b01 : 2'b00;
            w_mem_to_reg = (i_opcode == OP_LW) ? 2'b01 : 2'b00;
            w_next       = ST_FETCH;
         end
         ST_TRAP: w_illegal = 1'b1;
         default: w_next = ST_TRAP;
      endcase
   end

   // Reset forces every output low immediately, cancelling any in-flight strobe
   assign o_pc_we      = i_rst_n & w_pc_we;
   assign o_pc_src     = i_rst_n ? w_pc_src : 2'b00;
   assign o_ir_we      = i_rst_n & w_ir_we;
   assign o_iord       = i_rst_n & w_iord;
   assign o_mem_re     = i_rst_n & w_mem_re;
   assign o_mem_we     = i_rst_n & w_mem_we;
   assign o_reg_we     = i_rst_n & w_reg_we;
   assign o_reg_dst    = i_rst_n ? w_reg_dst : 2'b00;
   assign o_mem_to_reg = i_rst_n ? w_mem_to_reg : 2'b00;
   assign o_alu_src_a  = i_rst_n & w_alu_src_a;
   assign o_alu_src_b  = i_rst_n ? w_alu_src_b : 2'b00;
   assign o_alu_ctl    = i_rst_n ? w_alu_ctl : 4'b0000;
   assign o_state      = r_state;
   assign o_illegal    = i_rst_n & w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle output vectors.
module tb_multicycle_ctrl;

   localparam int WAIT_MAX = 15;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [3:0] C_AND  = 4'b0000;
   localparam logic [3:0] C_OR   = 4'b0001;
   localparam logic [3:0] C_ADD  = 4'b0010;
   localparam logic [3:0] C_SUB  = 4'b0110;
   localparam logic [3:0] C_SLT  = 4'b0111;
   localparam logic [3:0] C_SLTU = 4'b1000;

   typedef struct packed {
      logic [2:0] state;
      logic       illegal;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we;
      logic       iord;
      logic       mem_re;
      logic       mem_we;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_ctl;
   } out_t;

   localparam int OW = $bits(out_t);

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_we, ir_we, iord, mem_re, mem_we, reg_we, alu_src_a, illegal;
   logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [3:0]  alu_ctl;
   logic [2:0]  state;
   out_t        obs;

   logic [OW:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [5:0]  k_op[15] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_R, OP_ADDI, OP_ADDIU,
                             OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
   logic [5:0]  k_fn[15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

   multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_opcode     (opcode),
      .i_funct      (funct),
      .i_zero       (zero),
      .i_mem_ready  (mem_ready),
      .o_pc_we      (pc_we),
      .o_pc_src     (pc_src),
      .o_ir_we      (ir_we),
      .o_iord       (iord),
      .o_mem_re     (mem_re),
      .o_mem_we     (mem_we),
      .o_reg_we     (reg_we),
      .o_reg_dst    (reg_dst),
      .o_mem_to_reg (mem_to_reg),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_alu_ctl    (alu_ctl),
      .o_state      (state),
      .o_illegal    (illegal)
   );

   assign obs = {state, illegal, pc_we, pc_src, ir_we, iord, mem_re, mem_we, reg_we,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instruction-level reference model ----------------
   function automatic out_t st(input logic [2:0] s);
      out_t o;
      o       = '0;
      o.state = s;
      return o;
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input logic rdy, input out_t o);
      exp_q.push_back({rdy, o});
   endfunction

   function automatic void push_trap(input int n);
      out_t o;
      o         = st(3'd5);
      o.illegal = 1'b1;
      for (int k = 0; k < n; k++) push(rnd_bit(), o);
   endfunction

   // fw/mw: memory wait cycles before ready in FETCH/MEM; above WAIT_MAX the watchdog fires
   function automatic void push_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input int fw, input int mw);
      out_t o;
      o        = st(3'd0);
      o.mem_re = 1'b1;
      if (fw > WAIT_MAX) begin
         for (int k = 0; k <= WAIT_MAX; k++) push(1'b0, o);
         push_trap(4);
         return;
      end
      for (int k = 0; k < fw; k++) push(1'b0, o);
      o.ir_we = 1'b1; o.pc_we = 1'b1; o.alu_src_b = 2'b01; o.alu_ctl = C_ADD;
      push(1'b1, o);

      o = st(3'd1); o.alu_src_b = 2'b11; o.alu_ctl = C_ADD;
      if (op == OP_J || op == OP_JAL) begin
         o.pc_we = 1'b1; o.pc_src = 2'b10;
         if (op == OP_JAL) begin
            o.reg_we = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
         end
         push(rnd_bit(), o);
         return;
      end
      push(rnd_bit(), o);
      if (!(op inside {OP_R, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW, OP_BEQ})) begin
         push_trap(4);
         return;
      end

      o = st(3'd2); o.alu_src_a = 1'b1;
      if (op == OP_R) begin
         if (fn == 6'h08) begin
            o.pc_we = 1'b1; o.pc_src = 2'b11;
            push(rnd_bit(), o);
            return;
         end
         case (fn)
            6'h20: o.alu_ctl = C_ADD;
            6'h22: o.alu_ctl = C_SUB;
            6'h24: o.alu_ctl = C_AND;
            6'h25: o.alu_ctl = C_OR;
            6'h2A: o.alu_ctl = C_SLT;
            default: begin
               push(rnd_bit(), o);
               push_trap(4);
               return;
            end
         endcase
         push(rnd_bit(), o);
      end else if (op == OP_BEQ) begin
         o.alu_ctl = C_SUB; o.pc_src = 2'b01; o.pc_we = z;
         push(rnd_bit(), o);
         return;
      end else begin
         o.alu_src_b = 2'b10;
         o.alu_ctl = (op == OP_SLTI) ? C_SLT : (op == OP_SLTIU) ? C_SLTU : C_ADD;
         push(rnd_bit(), o);
      end

      if (op == OP_LW || op == OP_SW) begin
         o = st(3'd3); o.iord = 1'b1;
         o.mem_re = (op == OP_LW); o.mem_we = (op == OP_SW);
         if (mw > WAIT_MAX) begin
            for (int k = 0; k <= WAIT_MAX; k++) push(1'b0, o);
            push_trap(4);
            return;
         end
         for (int k = 0; k < mw; k++) push(1'b0, o);
         push(1'b1, o);
         if (op == OP_SW) return;
      end

      o = st(3'd4); o.reg_we = 1'b1;
      o.reg_dst    = (op == OP_R)  ? 2'b01 : 2'b00;
      o.mem_to_reg = (op == OP_LW) ? 2'b01 : 2'b00;
      push(rnd_bit(), o);
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string tag, input out_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0t: observed %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Entries are consumed one per cycle starting at a falling edge
   task automatic drain(input string tag, input int max_n);
      logic [OW:0] e;
      int          n;
      n = 0;
      while (exp_q.size() > 0 && n < max_n) begin
         e = exp_q.pop_front();
         mem_ready = e[OW];
         #1;
         check(tag, out_t'(e[OW-1:0]));
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fw, input int mw);
      opcode = op;
      funct  = fn;
      zero   = z;
      push_instr(op, fn, z, fw, mw);
      drain(tag, 1000);
   endtask

   task automatic apply_reset(input string tag);
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      #1;
      check(tag, '0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      out_t o;
      int   idx;
      rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
      @(negedge clk);
      apply_reset("reset_outputs");

      run_instr("r_add",     OP_R,   6'h20, 1'b0, 0, 0);
      run_instr("lw_wait3",  OP_LW,  6'h11, 1'b0, 0, 3);
      run_instr("beq_z1",    OP_BEQ, 6'h00, 1'b1, 0, 0);
      run_instr("beq_z0",    OP_BEQ, 6'h00, 1'b0, 0, 0);
      run_instr("jal",       OP_JAL, 6'h3F, 1'b0, 0, 0);
      run_instr("jr",        OP_R,   6'h08, 1'b0, 1, 0);

      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, 14);
         run_instr("random", k_op[idx], (k_op[idx] == OP_R) ? k_fn[idx] : 6'($urandom),
                   rnd_bit(), $urandom_range(0, 4), $urandom_range(0, 4));
      end

      run_instr("wd_fetch_edge", OP_ADDI, 6'h00, 1'b0, WAIT_MAX, 0);
      run_instr("wd_mem_edge",   OP_LW,   6'h00, 1'b0, 0, WAIT_MAX);

      run_instr("bad_opcode", 6'h3F, 6'h00, 1'b0, 0, 0);
      apply_reset("reset_from_trap_op");
      run_instr("bad_funct", OP_R, 6'h3F, 1'b0, 0, 0);
      apply_reset("reset_from_trap_fn");
      run_instr("wd_fetch_trap", OP_ADDI, 6'h00, 1'b0, WAIT_MAX + 1, 0);
      apply_reset("reset_from_wd_fetch");
      run_instr("wd_mem_trap", OP_SW, 6'h00, 1'b0, 0, WAIT_MAX + 1);
      apply_reset("reset_from_wd_mem");

      // Reset in the middle of an SW memory wait
      opcode = OP_SW; funct = 6'h00; zero = 1'b0;
      push_instr(OP_SW, 6'h00, 1'b0, 0, 5);
      drain("sw_pre_reset", 4);
      exp_q.delete();
      mem_ready = 1'b0;
      #1;
      o = st(3'd3); o.iord = 1'b1; o.mem_we = 1'b1;
      check("sw_mem_hold", o);
      #1 rst_n = 1'b0;
      #1 check("sw_reset_drop", '0);
      @(negedge clk);
      rst_n = 1'b1;

      run_instr("post_reset_j", OP_J, 6'h00, 1'b0, 0, 0);
      run_instr("post_reset_sw", OP_SW, 6'h00, 1'b0, 2, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the minimum MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every enable and mux select on the shared datapath: PC, IR, register file write port, ALU and unified memory. Memory accesses use a ready handshake with a watchdog. The block sits beside the datapath: it reads the opcode/funct fields, the ALU zero flag and memory ready, and it owns all write strobes.

## Interface
- WAIT_MAX, 15: maximum consecutive memory-wait cycles before entering TRAP (range 1–255).
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- Opcode  in  6  Ins[31:26] from IR.
- Funct  in  6  Ins[5:0] from IR.
- Zero  in  1  ALU result == 0.
- MemReady  in  1  memory completes the current access this cycle.
- PcWe  out  1  PC load enable.
- PcSrc  out  2  PC source: 00 ALU result, 01 ALUOut reg, 10 jump target, 11 Rdata1.
- IrWe  out  1  IR load enable.
- IorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemRe  out  1  memory read strobe.
- MemWe  out  1  memory write strobe.
- RegWe  out  1  register file write enable.
- RegDst  out  2  write address select: 00 Ins[20:16], 01 Ins[15:11], 10 r31.
- MemtoReg  out  2  write data select: 00 ALUOut, 01 MDR, 10 PC.
- AluSrcA  out  1  0 PC, 1 Rdata1.
- AluSrcB  out  2  00 Rdata2, 01 constant 4, 10 Ed32, 11 Ed32<<2.
- AluCtl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLTU.
- State  out  3  current state, for debug.
- Illegal  out  1  high while in TRAP.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6–7 go to TRAP.
- FETCH:
  - Drive MemRe=1, IorD=0.
  - Hold while MemReady=0.
  - On MemReady: IrWe=1, PcWe=1, PcSrc=00, AluSrcA=0, AluSrcB=01, AluCtl=ADD; go to DECODE.
- DECODE:
  - Drive AluSrcA=0, AluSrcB=11, AluCtl=ADD (branch target into ALUOut).
  - J: PcWe=1, PcSrc=10; go to FETCH.
  - JAL: J actions plus RegWe=1, RegDst=10, MemtoReg=10; go to FETCH.
  - Supported opcodes (R_FORM, ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ): go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC:
  - R_FORM: AluSrcA=1, AluSrcB=00.
    - AluCtl from Funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
    - Funct 0x08 (JR): PcWe=1, PcSrc=11; go to FETCH.
    - Any other Funct: go to TRAP.
  - ADDI/ADDIU: AluSrcA=1, AluSrcB=10, AluCtl=ADD; go to WB.
  - SLTI: as ADDI but AluCtl=SLT. SLTIU: AluCtl=SLTU.
  - LW/SW: AluSrcA=1, AluSrcB=10, AluCtl=ADD; go to MEM.
  - BEQ: AluSrcA=1, AluSrcB=00, AluCtl=SUB, PcSrc=01, PcWe=Zero; go to FETCH.
  - R-form arithmetic (ADD/SUB/AND/OR/SLT): go to WB.
- MEM:
  - Drive IorD=1; MemRe=1 for LW, MemWe=1 for SW.
  - Hold while MemReady=0.
  - On MemReady: SW goes to FETCH, LW goes to WB.
- WB:
  - RegWe=1.
  - RegDst=01 for R_FORM, else 00.
  - MemtoReg=01 for LW, else 00.
  - Go to FETCH.
- TRAP: every strobe and enable is 0, Illegal=1. Only reset leaves TRAP.
- Watchdog: an 8-bit counter increments each cycle spent in FETCH or MEM with MemReady=0 and clears on any state change. When the counter equals WAIT_MAX and MemReady=0, go to TRAP. If MemReady=1 in that same cycle, the handshake wins.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from state, Opcode/Funct, Zero and MemReady. The strobes gated by MemReady are Mealy.
- Latency with zero-wait memory:
  - J/JAL: 2 cycles.
  - BEQ, JR: 3 cycles.
  - SW, R-form arithmetic, I-type arithmetic: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Reset:
  - On RST_N assertion, State=FETCH and the counter=0 immediately.
  - While RST_N is low, all outputs are forced to 0 and any in-flight RegWe/MemWe/PcWe is dropped.
  - MemRe rises in the first cycle after RST_N deasserts.
- Opcode/Funct must be stable from the DECODE cycle through completion, because IR loads only in FETCH.

## Structure
- Shared constants in common_param.vh: existing opcode constants, plus new localparams for funct codes, state encodings and AluCtl codes.
- One sub-module, alu_dec: combinational decode of Opcode/Funct/state to AluCtl and a funct-valid flag.
- State register and watchdog counter live in multicycle_ctrl.

## Test plan
- Reset release, MemReady tied 1, R-form ADD (Funct 0x20) → FETCH, DECODE, EXEC, WB; RegWe=1 with RegDst=01 on cycle 4; AluCtl=0010 in EXEC.
- LW with MemReady low for 3 cycles in MEM → MemRe and IorD=1 held 4 cycles; WB with MemtoReg=01; total 8 cycles.
- BEQ with Zero=1, then with Zero=0 → PcWe=1, PcSrc=01 in EXEC for the first; PcWe=0 for the second; both return to FETCH on cycle 4.
- JAL → in DECODE: RegWe=1, RegDst=10, MemtoReg=10, PcWe=1, PcSrc=10; next state FETCH.
- Opcode 0x3F, and R-form Funct 0x3F → TRAP; Illegal=1, all strobes 0; remains until RST_N low.
- MemReady held 0 in FETCH with WAIT_MAX=15 → TRAP after 16 cycles. Repeat with MemReady=1 exactly on the 16th cycle → DECODE. Assert RST_N low mid-MEM of an SW → MemWe drops the same cycle and State=0.
